// File: rtl/falafel_mem_server.sv
// falafel_mem_server
// Word-organised SRAM endpoint for the falafel memory port. It serves one
// outstanding request at a time with a fixed, programmable latency. The
// request types are read, write and compare-and-swap. Each accepted request
// gets exactly one response.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   mem_req_*               request channel (val/rdy), byte address, data, CAS expected value
//   mem_rsp_*               response channel (val/rdy), data and error flag
//   init_we_i/addr_i/data_i backdoor word write, used to preload free-list headers
//   req_cnt_o               accepted request count (wraps)
//   err_cnt_o               errored request count (saturates)
module falafel_mem_server #(
   parameter int DATA_W   = 64,
   parameter int DEPTH    = 1024,
   parameter int LATENCY  = 2,
   parameter int ADDR_LSB = $clog2(DATA_W / 8)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     mem_req_val_i,
   output logic                     mem_req_rdy_o,
   input  logic                     mem_req_is_write_i,
   input  logic                     mem_req_is_cas_i,
   input  logic [DATA_W-1:0]        mem_req_addr_i,
   input  logic [DATA_W-1:0]        mem_req_data_i,
   input  logic [DATA_W-1:0]        mem_req_cas_exp_i,
   output logic                     mem_rsp_val_o,
   input  logic                     mem_rsp_rdy_i,
   output logic [DATA_W-1:0]        mem_rsp_data_o,
   output logic                     mem_rsp_err_o,
   input  logic                     init_we_i,
   input  logic [$clog2(DEPTH)-1:0] init_addr_i,
   input  logic [DATA_W-1:0]        init_data_i,
   output logic [31:0]              req_cnt_o,
   output logic [15:0]              err_cnt_o
);

   localparam int         IDX_W    = $clog2(DEPTH);
   localparam logic [3:0] LAT_INIT = 4'(LATENCY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [3:0]        lat_cnt_r;
   logic [3:0]        lat_cnt_nxt_s;
   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] rsp_data_r;
   logic              rsp_err_r;
   logic [31:0]       req_cnt_r;
   logic [15:0]       err_cnt_r;

   logic              accept_s;
   logic [IDX_W-1:0]  idx_s;
   logic              misalign_s;
   logic              range_err_s;
   logic              err_s;
   logic [DATA_W-1:0] old_s;
   logic              do_write_s;
   logic [DATA_W-1:0] rsp_data_nxt_s;

   // The backdoor has priority in IDLE. Reset also holds rdy low so nothing
   // is accepted while reset is asserted.
   assign mem_req_rdy_o  = (state_r == IDLE) && !init_we_i && !rst_i;
   assign accept_s       = mem_req_val_i && mem_req_rdy_o;
   assign mem_rsp_val_o  = (state_r == RESP);
   assign mem_rsp_data_o = rsp_data_r;
   assign mem_rsp_err_o  = rsp_err_r;
   assign req_cnt_o      = req_cnt_r;
   assign err_cnt_o      = err_cnt_r;

   // Request decode: word index, misalignment and out-of-range detection.
   assign idx_s       = mem_req_addr_i[ADDR_LSB +: IDX_W];
   assign misalign_s  = |mem_req_addr_i[ADDR_LSB-1:0];
   assign range_err_s = (mem_req_addr_i >> ADDR_LSB) >= DATA_W'(DEPTH);
   assign err_s       = misalign_s || range_err_s;
   assign old_s       = mem_r[idx_s];

   // Operation result and write enable, evaluated in the accept cycle.
   always_comb begin
      do_write_s     = 1'b0;
      rsp_data_nxt_s = {DATA_W{1'b0}};
      if (err_s) begin
         do_write_s     = 1'b0;
         rsp_data_nxt_s = {DATA_W{1'b0}};
      end else if (mem_req_is_write_i && mem_req_is_cas_i) begin
         // The CAS returns the old value. It writes only on a match.
         do_write_s     = (old_s == mem_req_cas_exp_i);
         rsp_data_nxt_s = old_s;
      end else if (mem_req_is_write_i) begin
         do_write_s     = 1'b1;
         rsp_data_nxt_s = mem_req_data_i;
      end else begin
         // A plain read. is_cas without is_write also lands here.
         do_write_s     = 1'b0;
         rsp_data_nxt_s = old_s;
      end
   end

   // Next-state and latency counter logic.
   always_comb begin
      state_nxt_s   = state_r;
      lat_cnt_nxt_s = lat_cnt_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (LATENCY == 0) begin
                  state_nxt_s = RESP;
               end else begin
                  state_nxt_s   = WAIT;
                  lat_cnt_nxt_s = LAT_INIT;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            if (lat_cnt_r == 4'd1) begin
               state_nxt_s   = RESP;
               lat_cnt_nxt_s = 4'd0;
            end else begin
               state_nxt_s   = WAIT;
               lat_cnt_nxt_s = lat_cnt_r - 4'd1;
            end
         end
         RESP: begin
            if (mem_rsp_rdy_i) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: begin
            state_nxt_s   = IDLE;
            lat_cnt_nxt_s = 4'd0;
         end
      endcase
   end

   // State register and latency counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r   <= IDLE;
         lat_cnt_r <= 4'd0;
      end else begin
         state_r   <= state_nxt_s;
         lat_cnt_r <= lat_cnt_nxt_s;
      end
   end

   // Response register. It loads only on accept, so backdoor writes made
   // during WAIT or RESP cannot disturb a response that is already captured.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_data_r <= {DATA_W{1'b0}};
         rsp_err_r  <= 1'b0;
      end else if (accept_s) begin
         rsp_data_r <= rsp_data_nxt_s;
         rsp_err_r  <= err_s;
      end
   end

   // Request and error counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_cnt_r <= 32'd0;
         err_cnt_r <= 16'd0;
      end else if (accept_s) begin
         req_cnt_r <= req_cnt_r + 32'd1;
         if (err_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
         end
      end
   end

   // Storage array, which is not reset. A request write and a backdoor write
   // never coincide, because the backdoor blocks the accept.
   always_ff @(posedge clk_i) begin
      if (accept_s && do_write_s) begin
         mem_r[idx_s] <= mem_req_data_i;
      end else if (init_we_i) begin
         mem_r[init_addr_i] <= init_data_i;
      end
   end

endmodule
